// File: rtl/dmem_pkg.sv
// Shared sizing constants and FSM state type for the data-memory arbiter.
package dmem_pkg;

   localparam int DMEM_ADDR_W  = 6;
   localparam int DMEM_DATA_W  = 32;
   localparam int DMEM_NUM_REQ = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } dmem_arb_state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int NUM_REQ = DMEM_NUM_REQ,
   parameter int ADDR_W  = DMEM_ADDR_W,
   parameter int DATA_W  = DMEM_DATA_W
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        we;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ*DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic                      mem_read;
   logic                      mem_write;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;

   modport slave (
      input  req, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational winner selection: one-hot winner plus its index.
// DMEM_ARB_RR_EN selects round-robin after ptr; otherwise lowest index wins.
module dmem_rr_pick
   import dmem_pkg::*;
#(
   parameter  int NUM_REQ = DMEM_NUM_REQ,
   localparam int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
`ifdef DMEM_ARB_RR_EN
   input  logic [IDX_W-1:0]   ptr,
`endif
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any
);
   logic found;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
`ifdef DMEM_ARB_RR_EN
      // Requesters above the last winner rank first; the wrap-around pass below covers the rest.
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i > int'(ptr))) begin
            win_oh[i] = 1'b1;
            win_idx   = IDX_W'(i);
            found     = 1'b1;
         end
      end
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            win_oh[i] = 1'b1;
            win_idx   = IDX_W'(i);
            found     = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: latches one winning command, drives the memory for one
// ISSUE cycle, then returns load data in RESP. Define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int NUM_REQ = DMEM_NUM_REQ,
   parameter int ADDR_W  = DMEM_ADDR_W,
   parameter int DATA_W  = DMEM_DATA_W
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);
   localparam int IDX_W = idx_width(NUM_REQ);

   dmem_arb_state_t    state_q, state_d;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;
   logic [IDX_W-1:0]   win_q;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               grant;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

`ifdef DMEM_ARB_RR_EN
   logic [IDX_W-1:0]   ptr_q;
`endif

   dmem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (bus.req),
`ifdef DMEM_ARB_RR_EN
      .ptr     (ptr_q),
`endif
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // ISSUE is the only cycle the memory is busy, so arbitration runs in IDLE and RESP.
   assign grant = pick_any && (state_q != ISSUE);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            sel_we    = bus.we[i];
            sel_addr  = bus.addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.gnt       = '0;
      bus.rvalid    = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      case (state_q)
         IDLE:  if (grant) state_d = ISSUE;
         ISSUE: begin
            state_d        = RESP;
            bus.gnt[win_q] = 1'b1;
            bus.mem_read   = !we_q;
            bus.mem_write  = we_q;
         end
         RESP: begin
            state_d = grant ? ISSUE : IDLE;
            if (!we_q) bus.rvalid[win_q] = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rdata     = rdata_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         win_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            win_q   <= pick_idx;
         end
         if (state_q == ISSUE && !we_q) rdata_q <= bus.mem_rdata;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Reset to the last index so requester 0 ranks first after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ptr_q <= IDX_W'(NUM_REQ - 1);
      else if (grant) ptr_q <= pick_idx;
   end
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory (64 × 32-bit, `MemRead`/`MemWrite` control, 6-bit word address). It sits between the memory and its clients: the core load/store path and the loader/debug port. It grants one access at a time and drives the memory control and address lines. It returns read data to the winning requester with a valid pulse.

## Interface
- `NUM_REQ`, default 2: number of requesters; fixed at 2 in this design.
- `ADDR_W`, default 6: word-address width; 64 words.
- `DATA_W`, default 32: data width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  NUM_REQ  request per requester; level, held until `gnt`.
- `we`  in  NUM_REQ  1 = store, 0 = load; per requester.
- `addr`  in  NUM_REQ*ADDR_W  flattened word addresses; requester i is at bits [i*ADDR_W +: ADDR_W].
- `wdata`  in  NUM_REQ*DATA_W  flattened store data.
- `gnt`  out  NUM_REQ  one-hot accept pulse, one cycle.
- `rvalid`  out  NUM_REQ  one-hot load-data-valid pulse, one cycle.
- `rdata`  out  DATA_W  load data; shared by all requesters, qualified by `rvalid`.
- `mem_read`  out  1  drives memory `MemRead`.
- `mem_write`  out  1  drives memory `MemWrite`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; combinational from `mem_addr` while `mem_read` is high.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:**
  - If any `req` is high at a clock edge, the arbiter picks a winner.
  - It latches the winner's `we`, `addr` and `wdata`, and records the winner index.
  - Next state is ISSUE. Otherwise it stays in IDLE.
- **ISSUE (exactly one cycle):**
  - `mem_read` equals `!we_q`; `mem_write` equals `we_q`.
  - `mem_addr` and `mem_wdata` come from the latched command.
  - `gnt[win]` is high.
  - On a load, `mem_rdata` is captured into `rdata` at the edge that ends ISSUE.
  - Next state is always RESP.
- **RESP:**
  - On a load, `rvalid[win]` is high; on a store, `rvalid` stays 0.
  - Memory controls are deasserted.
  - Arbitration runs exactly as in IDLE: a pending `req` goes straight to ISSUE, otherwise to IDLE.
- **Requester rule:** `req` must drop in the cycle after `gnt` is seen, unless a new request is intended. `req` high at the edge that ends RESP counts as a new request.
- **Arbitration:** see Configuration. The winner pointer updates only when a grant is made.
- `rdata` holds its last load value until the next load completes.
- Commands are latched, so input changes after the decision edge do not affect the access in flight.
- A `req` from a non-winner stays pending; it is never dropped.

## Timing
- Reset values:
  - State IDLE.
  - `gnt`, `rvalid`, `mem_read`, `mem_write` are 0.
  - `mem_addr`, `mem_wdata`, `rdata` are 0.
  - RR pointer equals NUM_REQ-1, so requester 0 is first in priority.
- All outputs are registered or decoded from registered state; there is no combinational path from `req` to `gnt`.
- Load latency: request sampled at edge t → `gnt` in cycle t+1 (ISSUE) → `rvalid` and `rdata` in cycle t+2.
- Store: memory write happens at the edge that ends ISSUE; `gnt` marks that cycle.
- Throughput:
  - One access every 2 cycles under continuous requests (ISSUE/RESP alternation).
  - 3 cycles from IDLE.
- `mem_read` and `mem_write` are never high together. Each is high for exactly one cycle per access.
- Reset asserted mid-access:
  - All outputs clear immediately (asynchronous); an in-flight store is abandoned.
  - No `rvalid` is produced for the aborted load.
  - After release, the block starts in IDLE with the pointer at its reset value.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. The search starts at pointer+1 modulo NUM_REQ; the pointer takes the winner index on each grant.
- Undefined: fixed priority; the lowest index wins. The pointer logic is not compiled in.

## Structure
- Package `dmem_pkg`:
  - State enum `dmem_arb_state_t` (IDLE, ISSUE, RESP).
  - Constants `DMEM_ADDR_W=6`, `DMEM_DATA_W=32`, `DMEM_NUM_REQ=2`.
- One sub-module, `dmem_rr_pick`: a combinational request vector plus pointer produces a one-hot winner and its index. It contains both the round-robin and the fixed-priority variants under the macro.
- The memory itself is instantiated alongside the arbiter, not inside it.

## Test plan
- Memory preloaded with word0 = 32'h6701ACE6. Requester 0 loads address 0 → `gnt[0]` 1 cycle later, `rvalid[0]` with `rdata` = 32'h6701ACE6 the cycle after; `mem_read` high for exactly 1 cycle.
- Requester 1 stores address 1, data 10 → `mem_write` high for 1 cycle with `mem_addr` = 1 and `mem_wdata` = 10; no `rvalid`. A following load of address 1 by requester 0 returns 10.
- Both requesters hold `req` for 8 accesses:
  - With `DMEM_ARB_RR_EN`: grants alternate 0,1,0,1…
  - Without it: only requester 0 is granted while it holds `req`.
- Requester 0 holds continuous loads of addresses 0..3 → `gnt` every 2nd cycle; `rvalid` data in address order.
- `rst_n` pulled low during an ISSUE store → `mem_write` drops immediately, that address keeps its old value, and no `gnt` or `rvalid` appears. After release, a simultaneous request from both requesters grants requester 0.
